flag_hazard_ctrl: RTL and testbench

FLAG_HAZARD_CTRL -- requirements
Module: flag_hazard_ctrl

---
 rtl/flag_hazard_ctrl_if.sv | 26 ++
 rtl/flag_hazard_ctrl.sv | 56 +++++
 tb/tb_flag_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_hazard_ctrl_if.sv
// flag_hazard_ctrl_if: ID/EX pipeline view, flag state and branch/perf outputs of the flag hazard controller
interface flag_hazard_ctrl_if;
  logic        id_valid;
  logic        id_is_bcond;
  logic [3:0]  id_cond;
  logic        ex_valid;
  logic        ex_setflags;
  logic [3:0]  flags_q;
  logic        stall_in;
  logic        flush_in;
  logic        flag_write;
  logic        br_stall;
  logic        br_resolved;
  logic        br_taken;
  logic [15:0] stall_cnt;
  logic [15:0] bcond_cnt;
  logic [15:0] taken_cnt;
  modport master (
    output id_valid, id_is_bcond, id_cond, ex_valid, ex_setflags, flags_q, stall_in, flush_in,
    input  flag_write, br_stall, br_resolved, br_taken, stall_cnt, bcond_cnt, taken_cnt
  );
  modport slave (
    input  id_valid, id_is_bcond, id_cond, ex_valid, ex_setflags, flags_q, stall_in, flush_in,
    output flag_write, br_stall, br_resolved, br_taken, stall_cnt, bcond_cnt, taken_cnt
  );
endinterface

// File: rtl/flag_hazard_ctrl.sv
// flag_hazard_ctrl: one-cycle stall of a B.cond behind a flag-setter in EX, condition evaluation, perf counters
module flag_hazard_ctrl (
  input logic             clk,
  input logic             reset,
  flag_hazard_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]  r_state;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_bcond_cnt;
  logic [15:0] r_taken_cnt;
  logic        w_n, w_z, w_c, w_v;
  logic [2:0]  w_cc;
  logic        w_base, w_cond;
  logic        w_run, w_bcond, w_setter, w_hazard;
  logic        w_stall, w_resolved, w_taken;
  assign {w_n, w_z, w_c, w_v} = bus.flags_q;
  assign w_cc = bus.id_cond[3:1];
  // odd codes invert their even partner, except AL (111x) which is always taken
  assign w_base = (w_cc == 3'd0) ? w_z :
                  (w_cc == 3'd1) ? w_c :
                  (w_cc == 3'd2) ? w_n :
                  (w_cc == 3'd3) ? w_v :
                  (w_cc == 3'd4) ? (w_c & ~w_z) :
                  (w_cc == 3'd5) ? (w_n == w_v) :
                  (w_cc == 3'd6) ? (~w_z & (w_n == w_v)) : 1'b1;
  assign w_cond = w_base ^ (bus.id_cond[0] & (w_cc != 3'd7));
  assign w_run      = reset & ~bus.stall_in & ~bus.flush_in;
  assign w_bcond    = bus.id_valid & bus.id_is_bcond;
  assign w_setter   = bus.ex_valid & bus.ex_setflags;
  assign w_hazard   = w_bcond & w_setter;
  assign w_stall    = w_run & (r_state == IDLE) & w_hazard;
  assign w_resolved = w_run & ((r_state == HOLD) | (w_bcond & ~w_setter));
  assign w_taken    = w_resolved & w_cond;
  assign bus.flag_write  = w_run & w_setter;
  assign bus.br_stall    = w_stall;
  assign bus.br_resolved = w_resolved;
  assign bus.br_taken    = w_taken;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.bcond_cnt   = r_bcond_cnt;
  assign bus.taken_cnt   = r_taken_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_stall_cnt <= 16'd0;
      r_bcond_cnt <= 16'd0;
      r_taken_cnt <= 16'd0;
    end else begin
      r_state     <= bus.flush_in ? IDLE : bus.stall_in ? r_state : w_stall ? HOLD : IDLE;
      r_stall_cnt <= r_stall_cnt + {15'd0, w_stall & ~&r_stall_cnt};
      r_bcond_cnt <= r_bcond_cnt + {15'd0, w_resolved & ~&r_bcond_cnt};
      r_taken_cnt <= r_taken_cnt + {15'd0, w_taken & ~&r_taken_cnt};
    end
  end
endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// tb_flag_hazard_ctrl: directed scenarios plus randomized traffic against a rule-level reference model
module tb_flag_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  flag_hazard_ctrl_if bus ();
  flag_hazard_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  logic        m_pend;
  logic [15:0] m_sc, m_bc, m_tc;
  logic        e_fw, e_st, e_res, e_tk;

  function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_eval();
    logic go, br, fs;
    go = reset && !bus.stall_in && !bus.flush_in;
    br = bus.id_valid && bus.id_is_bcond;
    fs = bus.ex_valid && bus.ex_setflags;
    e_fw  = go && fs;
    e_st  = go && !m_pend && br && fs;
    e_res = go && (m_pend || (br && !fs));
    e_tk  = e_res && ref_cond(bus.id_cond, bus.flags_q);
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_pend = 0; m_sc = 0; m_bc = 0; m_tc = 0;
    end else begin
      if (bus.flush_in) m_pend = 0;
      else if (!bus.stall_in) m_pend = e_st;
      if (e_st && m_sc != 16'hFFFF) m_sc++;
      if (e_res && m_bc != 16'hFFFF) m_bc++;
      if (e_tk && m_tc != 16'hFFFF) m_tc++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_is_bcond = 0; bus.id_cond = 0;
    bus.ex_valid = 0; bus.ex_setflags = 0; bus.flags_q = 0;
    bus.stall_in = 0; bus.flush_in = 0;
  endtask

  task automatic drive(input logic bc, input logic [3:0] cc, input logic fs, input logic [3:0] fl);
    bus.id_valid = bc; bus.id_is_bcond = bc; bus.id_cond = cc;
    bus.ex_valid = fs; bus.ex_setflags = fs; bus.flags_q = fl;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    tick();
    tick();
    reset = 1;
    m_pend = 0; m_sc = 0; m_bc = 0; m_tc = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    drive(1, 4'd14, 1, 4'hF);
    #3;
    checks++; if ({bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken} !== 4'b0000) begin failures++; $display("FAIL rst_outputs got=%b exp=0000", {bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken}); end
    checks++; if ({bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt} !== 48'd0) begin failures++; $display("FAIL rst_counters got=%h exp=0", {bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt}); end
    do_reset();
  endtask

  task automatic test_no_hazard();
    do_reset();
    drive(1, 4'd0, 0, 4'b0100);
    @(negedge clk);
    checks++; if (bus.br_resolved !== 1'b1) begin failures++; $display("FAIL eq_resolved got=%b exp=1", bus.br_resolved); end
    checks++; if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL eq_taken got=%b exp=1", bus.br_taken); end
    checks++; if (bus.br_stall !== 1'b0) begin failures++; $display("FAIL eq_stall got=%b exp=0", bus.br_stall); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.stall_cnt !== 16'd0 || bus.bcond_cnt !== 16'd1 || bus.taken_cnt !== 16'd1) begin failures++; $display("FAIL eq_counters got=%0d/%0d/%0d exp=0/1/1", bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt); end
    tick();
  endtask

  task automatic hazard_pair(input string tag);
    drive(1, 4'd1, 1, 4'b0000);
    @(negedge clk);
    checks++; if (bus.br_stall !== 1'b1 || bus.flag_write !== 1'b1 || bus.br_resolved !== 1'b0) begin failures++; $display("FAIL %s_c1 got stall=%b fw=%b res=%b exp 1 1 0", tag, bus.br_stall, bus.flag_write, bus.br_resolved); end
    tick();
    drive(1, 4'd1, 0, 4'b0100);
    @(negedge clk);
    checks++; if (bus.br_stall !== 1'b0 || bus.br_resolved !== 1'b1 || bus.br_taken !== 1'b0) begin failures++; $display("FAIL %s_c2 got stall=%b res=%b tk=%b exp 0 1 0", tag, bus.br_stall, bus.br_resolved, bus.br_taken); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.stall_cnt !== 16'd1 || bus.bcond_cnt !== 16'd1 || bus.taken_cnt !== 16'd0) begin failures++; $display("FAIL %s_cnt got=%0d/%0d/%0d exp=1/1/0", tag, bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt); end
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    hazard_pair("ne_hazard");
  endtask

  task automatic test_stall_in();
    do_reset();
    drive(1, 4'd1, 1, 4'b0000);
    bus.stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.br_stall, bus.flag_write, bus.br_resolved, bus.br_taken} !== 4'b0000) begin failures++; $display("FAIL frz_out%0d got=%b exp=0000", i, {bus.br_stall, bus.flag_write, bus.br_resolved, bus.br_taken}); end
      checks++; if ({bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt} !== 48'd0) begin failures++; $display("FAIL frz_cnt%0d got=%h exp=0", i, {bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt}); end
      tick();
    end
    bus.stall_in = 0;
    hazard_pair("frz_hazard");
  endtask

  task automatic test_flush_hold();
    do_reset();
    drive(1, 4'd14, 1, 4'b0000);
    tick();
    drive(1, 4'd14, 0, 4'b0000);
    bus.flush_in = 1;
    @(negedge clk);
    checks++; if ({bus.br_stall, bus.flag_write, bus.br_resolved} !== 3'b000) begin failures++; $display("FAIL flush_out got=%b exp=000", {bus.br_stall, bus.flag_write, bus.br_resolved}); end
    tick();
    bus.flush_in = 0;
    drive(1, 4'd14, 1, 4'b0000);
    @(negedge clk);
    checks++; if (bus.br_stall !== 1'b1 || bus.br_resolved !== 1'b0) begin failures++; $display("FAIL flush_idle got stall=%b res=%b exp 1 0", bus.br_stall, bus.br_resolved); end
    checks++; if (bus.bcond_cnt !== 16'd0) begin failures++; $display("FAIL flush_bcond got=%0d exp=0", bus.bcond_cnt); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive(1, 4'd14, 1, 4'b0000);
    tick();
    drive(1, 4'd14, 0, 4'b0000);
    @(negedge clk);
    checks++; if (bus.br_resolved !== 1'b1) begin failures++; $display("FAIL rhold_pre got=%b exp=1", bus.br_resolved); end
    #1 reset = 0;
    #1;
    checks++; if ({bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken} !== 4'b0000) begin failures++; $display("FAIL rhold_out got=%b exp=0000", {bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken}); end
    checks++; if ({bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt} !== 48'd0) begin failures++; $display("FAIL rhold_cnt got=%h exp=0", {bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt}); end
    tick();
    reset = 1;
    drive(1, 4'd14, 1, 4'b0000);
    @(negedge clk);
    checks++; if (bus.br_stall !== 1'b1 || bus.br_resolved !== 1'b0) begin failures++; $display("FAIL rhold_post got stall=%b res=%b exp 1 0", bus.br_stall, bus.br_resolved); end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_cond_sweep();
    int n_taken;
    n_taken = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        drive(1, 4'(c), 0, 4'(f));
        @(negedge clk);
        if (ref_cond(4'(c), 4'(f))) n_taken++;
        checks++; if (bus.br_resolved !== 1'b1 || bus.br_taken !== ref_cond(4'(c), 4'(f))) begin failures++; $display("FAIL sweep cc=%h fl=%b got res=%b tk=%b exp 1 %b", c, f, bus.br_resolved, bus.br_taken, ref_cond(4'(c), 4'(f))); end
        tick();
      end
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.bcond_cnt !== 16'd256 || bus.taken_cnt !== 16'(n_taken)) begin failures++; $display("FAIL sweep_cnt got=%0d/%0d exp=256/%0d", bus.bcond_cnt, bus.taken_cnt, n_taken); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.r_stall_cnt = 16'hFFFE;
    force dut.r_bcond_cnt = 16'hFFFE;
    force dut.r_taken_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    release dut.r_bcond_cnt;
    release dut.r_taken_cnt;
    for (int h = 0; h < 3; h++) begin
      drive(1, 4'd14, 1, 4'b0000);
      tick();
      drive(1, 4'd14, 0, 4'b0000);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++; if (bus.stall_cnt !== 16'hFFFF || bus.bcond_cnt !== 16'hFFFF || bus.taken_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat%0d got=%h/%h/%h exp=ffff", h, bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt); end
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.id_valid    = 1'($urandom_range(0, 3) != 0);
      bus.id_is_bcond = 1'($urandom_range(0, 2) != 0);
      bus.id_cond     = 4'($urandom);
      bus.ex_valid    = 1'($urandom);
      bus.ex_setflags = 1'($urandom);
      bus.flags_q     = 4'($urandom);
      bus.stall_in    = 1'($urandom_range(0, 5) == 0);
      bus.flush_in    = 1'($urandom_range(0, 9) == 0);
      @(negedge clk);
      model_eval();
      checks++; if ({bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken} !== {e_fw, e_st, e_res, e_tk}) begin failures++; $display("FAIL rnd_out%0d got=%b exp=%b", i, {bus.flag_write, bus.br_stall, bus.br_resolved, bus.br_taken}, {e_fw, e_st, e_res, e_tk}); end
      checks++; if ({bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt} !== {m_sc, m_bc, m_tc}) begin failures++; $display("FAIL rnd_cnt%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, bus.stall_cnt, bus.bcond_cnt, bus.taken_cnt, m_sc, m_bc, m_tc); end
      model_commit();
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    m_pend = 0; m_sc = 0; m_bc = 0; m_tc = 0;
    #2;
    test_reset();
    test_no_hazard();
    test_hazard();
    test_stall_in();
    test_flush_hold();
    test_reset_mid_hold();
    test_cond_sweep();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
